// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: 2-bit counter encodings,
// the reset/allocate counter values, the per-entry state record and the
// saturating step helper used by every counter instance.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  // Counter encodings: the MSB is the taken/not-taken prediction.
  localparam ctr_t CTR_SNT = 2'b00;  // strong not-taken
  localparam ctr_t CTR_WNT = 2'b01;  // weak not-taken
  localparam ctr_t CTR_WT  = 2'b10;  // weak taken
  localparam ctr_t CTR_ST  = 2'b11;  // strong taken

  // A cleared entry leans not-taken; a freshly allocated branch leans taken.
  localparam ctr_t CTR_RESET = CTR_WNT;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  // Width-independent part of a table entry. Tag and target widths depend
  // on the instance parameters, so they live in parallel arrays.
  typedef struct packed {
    logic valid;
    ctr_t ctr;
  } entry_t;

  // One saturating step of a 2-bit counter in the requested direction.
  function automatic ctr_t sat_step(input ctr_t c, input logic up);
    ctr_t r;
    r = c;
    if (up && c != CTR_ST) r = c + 2'd1;
    if (!up && c != CTR_SNT) r = c - 2'd1;
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Predictor bus: fetch-stage lookup and decode-stage resolution signals.
//
// Handshake: there is no backpressure. The lookup (f_pc -> pred_*) is
// evaluated every cycle. res_valid qualifies all res_* inputs for exactly
// the cycle it is high; the predictor always accepts it, and res_mispredict
// is only ever asserted in a cycle where res_valid is high.
interface branch_predictor_bht_if #(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6
);
  logic [XLEN-1:0]       f_pc;
  logic                  pred_taken;
  logic [XLEN-1:0]       pred_target;
  logic [INDEX_BITS-1:0] pred_index;

  logic                  res_valid;
  logic [XLEN-1:0]       res_pc;
  logic [INDEX_BITS-1:0] res_index;
  logic                  res_is_branch;
  logic                  res_is_jump;
  logic                  res_taken;
  logic [XLEN-1:0]       res_target;
  logic                  res_pred_taken;
  logic [XLEN-1:0]       res_pred_target;
  logic                  res_mispredict;
  logic [XLEN-1:0]       res_redirect_pc;

  // Pipeline side: drives PCs and resolution results.
  modport master (
    output f_pc, res_valid, res_pc, res_index, res_is_branch, res_is_jump,
           res_taken, res_target, res_pred_taken, res_pred_target,
    input  pred_taken, pred_target, pred_index, res_mispredict, res_redirect_pc
  );

  // Predictor side.
  modport slave (
    input  f_pc, res_valid, res_pc, res_index, res_is_branch, res_is_jump,
           res_taken, res_target, res_pred_taken, res_pred_target,
    output pred_taken, pred_target, pred_index, res_mispredict, res_redirect_pc
  );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter with a load port. Load wins over inc/dec;
// simultaneous inc and dec hold the value.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  ctr_t load_val,
  input  logic inc,
  input  logic dec,
  output ctr_t ctr
);

  // Counter state: reset value, then load, then saturating step.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctr <= CTR_RESET;
    end else if (load) begin
      ctr <= load_val;
    end else if (inc && !dec) begin
      ctr <= sat_step(ctr, 1'b1);
    end else if (dec && !inc) begin
      ctr <= sat_step(ctr, 1'b0);
    end
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Dynamic branch predictor: 2-bit counter table plus tagged BTB, looked up
// combinationally by the fetch PC and trained by decode-stage resolution.
// Optional feature macro GSHARE_EN: XOR a non-speculative global history
// register into the lookup index. Without it the table is bimodal.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int HIST_BITS  = 6
) (
  input logic clk,
  input logic reset,
  branch_predictor_bht_if.slave bus
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];
  ctr_t ctr_q [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx;
  logic [TAG_BITS-1:0] f_tag;
  entry_t f_ent;
  logic f_hit;

  logic upd;
  logic is_jump;
  logic is_br;
  logic [TAG_BITS-1:0] r_tag;
  logic r_hit;
  logic entry_wr;
  logic ctr_load;
  ctr_t ctr_load_val;
  logic ctr_inc;
  logic ctr_dec;

`ifdef GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q;
  logic [INDEX_BITS-1:0] ghr_ext;

  // Zero-extend the history to the index width (works when equal widths).
  always_comb begin
    ghr_ext = '0;
    ghr_ext[HIST_BITS-1:0] = ghr_q;
  end

  assign f_idx = bus.f_pc[INDEX_BITS+1:2] ^ ghr_ext;

  // History shifts in committed branch outcomes only; jumps do not enter it.
  always_ff @(posedge clk) begin
    if (reset) begin
      ghr_q <= '0;
    end else if (upd && is_br) begin
      ghr_q <= {ghr_q[HIST_BITS-2:0], bus.res_taken};
    end
  end
`else
  localparam int unused_hist_bits = HIST_BITS;
  assign f_idx = bus.f_pc[INDEX_BITS+1:2];
`endif

  // Lookup: read straight from the flops, so a same-cycle update is not seen.
  always_comb begin
    f_tag = bus.f_pc[TAG_HI:TAG_LO];
    f_ent = '{valid: valid_q[f_idx], ctr: ctr_q[f_idx]};
    f_hit = f_ent.valid && (tag_q[f_idx] == f_tag);
  end

  assign bus.pred_index  = f_idx;
  assign bus.pred_taken  = f_hit & f_ent.ctr[1];
  assign bus.pred_target = bus.pred_taken ? target_q[f_idx] : bus.f_pc + XLEN'(4);

  // Training decode: a jump (including the both-flags case) always refreshes
  // the entry as strong-taken; a branch steps on a hit, allocates on a taken
  // miss and leaves the table alone on a not-taken miss.
  always_comb begin
    upd          = bus.res_valid & (bus.res_is_branch | bus.res_is_jump);
    is_jump      = bus.res_is_jump;
    is_br        = bus.res_is_branch & ~bus.res_is_jump;
    r_tag        = bus.res_pc[TAG_HI:TAG_LO];
    r_hit        = valid_q[bus.res_index] && (tag_q[bus.res_index] == r_tag);
    entry_wr     = upd & (is_jump | (is_br & bus.res_taken));
    ctr_load     = upd & (is_jump | (is_br & ~r_hit & bus.res_taken));
    ctr_load_val = is_jump ? CTR_ST : CTR_ALLOC;
    ctr_inc      = upd & is_br & r_hit & bus.res_taken;
    ctr_dec      = upd & is_br & r_hit & ~bus.res_taken;
  end

  // Valid/tag/target storage; a taken hit rewrites identical valid/tag.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (entry_wr) begin
      valid_q[bus.res_index]  <= 1'b1;
      tag_q[bus.res_index]    <= r_tag;
      target_q[bus.res_index] <= bus.res_target;
    end
  end

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
    logic sel;
    assign sel = (bus.res_index == INDEX_BITS'(g));
    bp_sat_counter u_ctr (
      .clk      (clk),
      .reset    (reset),
      .load     (ctr_load & sel),
      .load_val (ctr_load_val),
      .inc      (ctr_inc & sel),
      .dec      (ctr_dec & sel),
      .ctr      (ctr_q[g])
    );
  end

  // Redirect: any direction error, or a taken outcome with a wrong target.
  always_comb begin
    bus.res_mispredict  = upd & ((bus.res_taken != bus.res_pred_taken) |
                                 (bus.res_taken & (bus.res_target != bus.res_pred_target)));
    bus.res_redirect_pc = bus.res_taken ? bus.res_target : bus.res_pc + XLEN'(4);
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Testbench for branch_predictor_bht: directed plan plus random training,
// scoreboarded against a table model built from the predictor's rules.
module tb_branch_predictor_bht;

  localparam int XLEN       = 32;
  localparam int INDEX_BITS = 6;
  localparam int TAG_BITS   = 8;
  localparam int HIST_BITS  = 6;
  localparam int ENTRIES    = 1 << INDEX_BITS;
  localparam int W          = 1 + XLEN + INDEX_BITS + 1 + XLEN;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  branch_predictor_bht_if #(.XLEN(XLEN), .INDEX_BITS(INDEX_BITS)) bus ();

  branch_predictor_bht #(
    .XLEN(XLEN), .INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS), .HIST_BITS(HIST_BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // ---------------- reference model ----------------
  bit              m_valid [ENTRIES];
  logic [TAG_BITS-1:0] m_tag [ENTRIES];
  logic [XLEN-1:0] m_tgt   [ENTRIES];
  int              m_ctr   [ENTRIES];
  int              m_ghr;

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_ghr = 0;
  endfunction

  function automatic logic [INDEX_BITS-1:0] m_index(input logic [XLEN-1:0] pc);
    int base;
    base = int'((pc >> 2) % ENTRIES);
`ifdef GSHARE_EN
    base = base ^ m_ghr;
`endif
    return INDEX_BITS'(base);
  endfunction

  function automatic logic [TAG_BITS-1:0] m_tag_of(input logic [XLEN-1:0] pc);
    return TAG_BITS'((pc >> (INDEX_BITS + 2)) % (1 << TAG_BITS));
  endfunction

  function automatic void m_predict(input logic [XLEN-1:0] pc, output logic tk,
                                    output logic [XLEN-1:0] tgt);
    int i;
    bit hit;
    i   = int'(m_index(pc));
    hit = m_valid[i] && (m_tag[i] == m_tag_of(pc));
    tk  = hit && (m_ctr[i] >= 2);
    tgt = tk ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_update(input logic [XLEN-1:0] rpc, input logic [INDEX_BITS-1:0] ridx,
                                   input logic br, input logic jmp, input logic tk,
                                   input logic [XLEN-1:0] tgt);
    int i;
    bit hit;
    i   = int'(ridx);
    hit = m_valid[i] && (m_tag[i] == m_tag_of(rpc));
    if (jmp) begin
      m_valid[i] = 1; m_tag[i] = m_tag_of(rpc); m_tgt[i] = tgt; m_ctr[i] = 3;
    end else if (br) begin
      if (hit && tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end else if (tk) begin
        m_valid[i] = 1; m_tag[i] = m_tag_of(rpc); m_tgt[i] = tgt; m_ctr[i] = 2;
      end
      m_ghr = ((m_ghr << 1) | int'(tk)) % (1 << HIST_BITS);
    end
  endfunction

  // ---------------- driver tasks ----------------
  // One cycle of stimulus: drive, push expected (pre-update view), train model.
  task automatic step(input logic [XLEN-1:0] fpc, input logic rv, input logic [XLEN-1:0] rpc,
                      input logic [INDEX_BITS-1:0] ridx, input logic br, input logic jmp,
                      input logic tk, input logic [XLEN-1:0] tgt, input logic ppt,
                      input logic [XLEN-1:0] pptgt);
    logic e_tk;
    logic [XLEN-1:0] e_tgt;
    logic e_mis;
    logic [XLEN-1:0] e_redir;
    @(posedge clk);
    #1;
    reset               = 1'b0;
    bus.f_pc            = fpc;
    bus.res_valid       = rv;
    bus.res_pc          = rpc;
    bus.res_index       = ridx;
    bus.res_is_branch   = br;
    bus.res_is_jump     = jmp;
    bus.res_taken       = tk;
    bus.res_target      = tgt;
    bus.res_pred_taken  = ppt;
    bus.res_pred_target = pptgt;
    m_predict(fpc, e_tk, e_tgt);
    e_mis   = rv && (br || jmp) && ((tk != ppt) || (tk && (tgt != pptgt)));
    e_redir = tk ? tgt : rpc + 32'd4;
    exp_q.push_back({e_tk, e_tgt, m_index(fpc), e_mis, e_redir});
    chk_en = 1'b1;
    if (rv && (br || jmp)) m_update(rpc, ridx, br, jmp, tk, tgt);
  endtask

  // Resolution that carries the prediction the front end would have made.
  task automatic resolve(input logic [XLEN-1:0] fpc, input logic [XLEN-1:0] rpc,
                         input logic br, input logic jmp, input logic tk,
                         input logic [XLEN-1:0] tgt);
    logic ppt;
    logic [XLEN-1:0] pptgt;
    m_predict(rpc, ppt, pptgt);
    step(fpc, 1'b1, rpc, m_index(rpc), br, jmp, tk, tgt, ppt, pptgt);
  endtask

  task automatic lookup(input logic [XLEN-1:0] fpc);
    step(fpc, 1'b0, fpc, '0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // Reset held for one edge while a jump resolution is also presented.
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset               = 1'b1;
    chk_en              = 1'b0;
    bus.f_pc            = 32'h100;
    bus.res_valid       = 1'b1;
    bus.res_pc          = 32'h100;
    bus.res_index       = m_index(32'h100);
    bus.res_is_branch   = 1'b0;
    bus.res_is_jump     = 1'b1;
    bus.res_taken       = 1'b1;
    bus.res_target      = 32'h0000_0abc;
    bus.res_pred_taken  = 1'b0;
    bus.res_pred_target = 32'h0;
    model_reset();
  endtask

  function automatic logic [XLEN-1:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return $urandom & ~32'h3;
    return (XLEN'($urandom_range(0, 3)) << (INDEX_BITS + 2)) |
           (XLEN'($urandom_range(0, ENTRIES - 1)) << 2);
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      logic [W-1:0] got;
      logic [W-1:0] exp;
      got = {bus.pred_taken, bus.pred_target, bus.pred_index, bus.res_mispredict,
             bus.res_redirect_pc};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty got=%h", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL predict_resolve t=%0t f_pc=%h got tk=%b tgt=%h idx=%0d mis=%b redir=%h exp tk=%b tgt=%h idx=%0d mis=%b redir=%h",
                   $time, bus.f_pc, got[W-1], got[W-2 -: XLEN], got[XLEN+INDEX_BITS:XLEN+1],
                   got[XLEN], got[XLEN-1:0], exp[W-1], exp[W-2 -: XLEN],
                   exp[XLEN+INDEX_BITS:XLEN+1], exp[XLEN], exp[XLEN-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [XLEN-1:0] rpc, fpc, tgt, pptgt;
    logic br, jmp, tk, ppt, rv;
    logic [INDEX_BITS-1:0] ridx;
    int r;

    model_reset();
    bus.f_pc = 32'h0; bus.res_valid = 1'b0; bus.res_pc = 32'h0; bus.res_index = '0;
    bus.res_is_branch = 1'b0; bus.res_is_jump = 1'b0; bus.res_taken = 1'b0;
    bus.res_target = 32'h0; bus.res_pred_taken = 1'b0; bus.res_pred_target = 32'h0;
    do_reset();

    // Cold lookup, then a mispredicted taken branch, then the trained lookup.
    lookup(32'h100);
    resolve(32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
    lookup(32'h100);
    // Walk the counter down past saturation, then back up past saturation.
    for (int k = 0; k < 3; k++) begin
      resolve(32'h100, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80);
      lookup(32'h100);
    end
    for (int k = 0; k < 4; k++) begin
      resolve(32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80);
      lookup(32'h100);
    end
    // JAL allocation and a correctly predicted re-resolution.
    resolve(32'h104, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400);
    lookup(32'h200);
    resolve(32'h200, 32'h200, 1'b0, 1'b1, 1'b1, 32'h400);
    // Aliasing at index 0: lookups of both PCs, then the other one evicts.
    lookup(32'h100);
    resolve(32'h100, 32'h100, 1'b1, 1'b0, 1'b1, 32'h40);
    lookup(32'h200);
    lookup(32'h100);
    // Both flags high behaves as a jump.
    resolve(32'h108, 32'h108, 1'b1, 1'b1, 1'b1, 32'h1000);
    lookup(32'h108);
    // PC+4 wraparound on lookup and redirect.
    lookup(32'hffff_fffc);
    resolve(32'hffff_fffc, 32'hffff_fffc, 1'b1, 1'b0, 1'b0, 32'h10);
    // Non-branch resolution never trains or mispredicts.
    step(32'h100, 1'b1, 32'h100, m_index(32'h100), 1'b0, 1'b0, 1'b1, 32'h44, 1'b0, 32'h0);
    lookup(32'h100);
    // Reset in the middle of training wins over the coincident jump.
    do_reset();
    lookup(32'h100);
    lookup(32'h200);
    // Alternating T,N branch at one PC.
    for (int k = 0; k < 40; k++) begin
      resolve(32'h300, 32'h300, 1'b1, 1'b0, ((k % 2) == 0), 32'h700);
    end

    // Random training with carried or corrupted predictions.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      rpc = rand_pc();
      fpc = ($urandom_range(0, 1) == 0) ? rpc : rand_pc();
      rv  = ($urandom_range(0, 3) != 0);
      r   = $urandom_range(0, 7);
      br  = (r <= 3) || (r == 6);
      jmp = (r == 4) || (r == 5) || (r == 6);
      tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
      tgt = $urandom & ~32'h3;
      m_predict(rpc, ppt, pptgt);
      if ($urandom_range(0, 3) == 0) begin
        ppt   = 1'($urandom_range(0, 1));
        pptgt = ($urandom_range(0, 1) == 0) ? tgt : ($urandom & ~32'h3);
      end
      ridx = ($urandom_range(0, 7) == 0) ? INDEX_BITS'($urandom_range(0, ENTRIES - 1))
                                         : m_index(rpc);
      step(fpc, rv, rpc, ridx, br, jmp, tk, tgt, ppt, pptgt);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised dynamic branch predictor for the pipelined RISC-V core: a table of 2-bit saturating counters plus a tagged branch target buffer, looked up by the fetch-stage PC, trained by the decode-stage branch resolution result. It replaces static not-taken fetch with a per-PC taken/not-taken and target prediction. It also flags mispredicts so the hazard unit can flush and redirect.

## Interface
- XLEN, 32, data/address width
- INDEX_BITS, 6, table index width; ENTRIES = 2**INDEX_BITS
- TAG_BITS, 8, BTB tag width, taken from PC bits above the index
- HIST_BITS, 6, global history length (used only with GSHARE_EN; HIST_BITS <= INDEX_BITS)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- f_pc  in  XLEN  fetch-stage PC
- pred_taken  out  1  predicted taken
- pred_target  out  XLEN  predicted next PC
- pred_index  out  INDEX_BITS  table index used; carried down the pipe
- res_valid  in  1  resolution event this cycle
- res_pc  in  XLEN  PC of resolved instruction
- res_index  in  INDEX_BITS  pred_index carried with it
- res_is_branch  in  1  conditional branch (opcode 1100011)
- res_is_jump  in  1  JAL (opcode 1101111)
- res_taken  in  1  actual outcome (jumps: 1)
- res_target  in  XLEN  actual taken target
- res_pred_taken  in  1  prediction carried with it
- res_pred_target  in  XLEN  prediction carried with it
- res_mispredict  out  1  redirect required
- res_redirect_pc  out  XLEN  correct next PC

## Operation
- Entry: valid, tag[TAG_BITS], target[XLEN], ctr[2]. ctr: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Index: f_pc[INDEX_BITS+1:2]; tag: f_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2].
- Hit = valid & tag match. pred_taken = hit & ctr[1]. pred_target = pred_taken ? target : f_pc+4.
- Update only when res_valid & (res_is_branch | res_is_jump); entry at res_index, tag from res_pc.
- Branch, hit: taken -> ctr+1 saturating at 11, target <= res_target; not taken -> ctr-1 saturating at 00.
- Branch, miss, taken: allocate (valid=1, new tag, target, ctr=10), overwriting any occupant. Miss, not taken: no write.
- Jump: allocate or refresh with ctr=11, target=res_target.
- res_mispredict = res_valid & (res_is_branch|res_is_jump) & ((res_taken != res_pred_taken) | (res_taken & res_target != res_pred_target)); 0 otherwise.
- res_redirect_pc = res_taken ? res_target : res_pc+4.
- res_is_branch and res_is_jump both high: treated as jump.

## Timing
- Lookup combinational from flops, zero latency, same cycle as f_pc.
- Update written on the clk edge ending the res_valid cycle; visible to lookups from the next cycle.
- Same-cycle lookup and update of one index: lookup returns pre-update contents (read-before-write).
- res_mispredict / res_redirect_pc combinational from res_* inputs, same cycle.
- Reset: all valid=0, ctr=01, target=0, tag=0, history=0; hence pred_taken=0, pred_target=f_pc+4 from the first post-reset cycle. Reset dominates a coincident res_valid. Reset mid-training discards all state.
- PC+4 arithmetic wraps modulo 2**XLEN.

## Configuration
- GSHARE_EN defined: index = f_pc[INDEX_BITS+1:2] XOR zero-extended ghr[HIST_BITS-1:0]. ghr <= {ghr[HIST_BITS-2:0], res_taken} on each branch update (not jumps). History is non-speculative.
- GSHARE_EN undefined: bimodal indexing, no history register. Ports identical.

## Structure
- Package bp_pkg: counter encodings (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST), reset value CTR_WNT, allocate value CTR_WT, entry struct typedef.
- Sub-module bp_sat_counter: 2-bit saturating inc/dec with a load port; one instance per entry.

## Test plan
- Reset, then f_pc=0x100 -> pred_taken=0, pred_target=0x104, pred_index=0.
- Resolve taken branch pc=0x100 target=0x80 with pred 0 -> res_mispredict=1, redirect 0x80; next cycle f_pc=0x100 -> pred_taken=1, pred_target=0x80.
- Same branch resolved not-taken twice -> ctr 10->01->00; lookup pred_taken=0; a third not-taken keeps 00 (saturation); four takens reach 11 and saturate.
- JAL pc=0x200 target=0x400 -> entry ctr=11; lookup predicts 0x400; resolving with pred 1/0x400 -> res_mispredict=0.
- Aliasing: pc=0x100 and 0x100+(4<<INDEX_BITS) -> tag mismatch, no false hit; taken second allocates and evicts first.
- Same-cycle lookup/update at one index -> old prediction that cycle, new next; with GSHARE_EN, taken-branch pattern T,N repeating reaches 100% prediction after warm-up.
